codec_cfg_arbiter: RTL and testbench
====================================

Name: codec_cfg_arbiter

Overview:
Shares one byte-level I2C master engine between NUM_REQ register-write requesters, such as the boot-time codec init sequencer and the runtime volume/mute control. The block arbitrates round-robin and sequences each transaction as START + device address (W), register address high byte, register address low byte, data byte, STOP. It checks ACK on every byte, retries the whole transaction on NACK, and reports done/error to the requester that was granted. It sits between the audio control logic and the I2C engine that drives SCL/SDA.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DEV_ADDR, 7'h3B, 7-bit codec I2C address
MAX_RETRY, 3, retries after the first NACKed attempt (0..15)
RETRY_GAP, 1000, idle clk cycles between a failed attempt's STOP and the retry (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request; held until req_ready
req_addr  in  16*NUM_REQ  register address, requester i at [16i+15:16i]
req_data  in  8*NUM_REQ  write data, requester i at [8i+7:8i]
req_ready  out  NUM_REQ  one-cycle accept pulse; request latched
req_done  out  NUM_REQ  one-cycle completion pulse
req_err  out  NUM_REQ  valid with req_done; 1 = all attempts NACKed
busy  out  1  high whenever state != IDLE
eng_cmd_valid  out  1  command to engine valid
eng_cmd_ready  in  1  engine accepts command when valid&ready
eng_cmd_start  out  1  issue START (or repeated START) before the byte
eng_cmd_stop  out  1  command is STOP only (byte ignored)
eng_cmd_byte  out  8  byte to transmit
eng_done  in  1  one-cycle pulse: previous command finished
eng_ack  in  1  valid with eng_done on byte commands; 1 = slave ACKed

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; rr_ptr=0; retry count, byte index and latched request cleared. A reset mid-transaction abandons it with no done pulse and no STOP. The engine is reset by the same rst_n.
- All outputs are registered.
- IDLE: if any req_valid is set, grant g = first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ. Latch addr/data[g]. Next cycle pulse req_ready[g]=1 and enter SEND with idx=0 and retry=0. Requests dropped before the grant cycle are not granted.
- SEND: eng_cmd_valid=1. eng_cmd_start=(idx==0). eng_cmd_stop=0. Byte: idx0={DEV_ADDR,1'b0}, idx1=addr[15:8], idx2=addr[7:0], idx3=data. Payload is held stable until eng_cmd_ready. On the handshake cycle: valid drops next cycle, go WAIT_BYTE.
- WAIT_BYTE: on eng_done, if eng_ack=1 and idx<3, then idx++ and go SEND. If eng_ack=1 and idx==3, nack=0 and go STOP. If eng_ack=0, nack=1 and go STOP immediately; remaining bytes are not sent.
- STOP: eng_cmd_valid=1, eng_cmd_stop=1, eng_cmd_start=0. On handshake go WAIT_STOP.
- WAIT_STOP: on eng_done (eng_ack ignored):
  - nack=0: go RESP.
  - nack=1 and retry<MAX_RETRY: retry++, load gap counter with RETRY_GAP, go GAP.
  - otherwise: go RESP.
- GAP: decrement counter each cycle; on reaching 0 go SEND with idx=0.
- RESP: pulse req_done[g]=1 with req_err[g]=nack for one cycle. Set rr_ptr=(g+1) mod NUM_REQ. Return to IDLE. New arbitration can start the cycle after.
- eng_done outside the WAIT_* states is ignored. eng_done arriving in the same cycle as the handshake is not expected; it is ignored.
- Total attempts per request = 1+MAX_RETRY. Requests from other requesters wait; there is no preemption.
- Minimum latency with an engine that is ready immediately and completes immediately: req_valid to req_ready = 2 cycles.

Test Plan:
- Single write: req0 addr=16'h4015, data=8'h01, engine always ACKs -> one req_ready[0] pulse; bytes 76,40,15,01 with start only on 76; then STOP; req_done[0]=1, req_err[0]=0; busy falls.
- Round-robin: req0 and req1 both held valid continuously for 4 transactions -> grants in order 0,1,0,1; no req_done overlap.
- NACK then recover: engine NACKs byte idx1 on attempt 1 only -> STOP issued right after idx1; exactly RETRY_GAP idle cycles; attempt 2 completes; req_err=0.
- NACK exhaust: MAX_RETRY=3, DEV_ADDR always NACKed -> 4 attempts of START+76 then STOP each; req_done with req_err=1.
- Backpressure: eng_cmd_ready held low 20 cycles during idx2 -> eng_cmd_byte=15 and valid held stable throughout; no byte skipped.
- Reset mid-transaction: drop rst_n during WAIT_BYTE idx2 -> all outputs 0 immediately; after release, a fresh req1 is served first from rr_ptr=0 scan.

Source files
------------

// File: rtl/codec_cfg_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine between
// several register-write requesters, with whole-transaction retry on NACK.
module codec_cfg_arbiter #(
    parameter int         NUM_REQ   = 2,
    parameter logic [6:0] DEV_ADDR  = 7'h3B,
    parameter int         MAX_RETRY = 3,
    parameter int         RETRY_GAP = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_err,
    output logic                  busy,
    output logic                  eng_cmd_valid,
    input  logic                  eng_cmd_ready,
    output logic                  eng_cmd_start,
    output logic                  eng_cmd_stop,
    output logic [7:0]            eng_cmd_byte,
    input  logic                  eng_done,
    input  logic                  eng_ack
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE, GRANT, SEND, WAIT_BYTE, STOP, WAIT_STOP, GAP, RESP
    } state_t;

    state_t              state;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       gnt;
    logic [GW-1:0]       pick;
    logic                pick_found;
    logic [GW:0]         cand;
    logic [15:0]         lat_addr;
    logic [7:0]          lat_data;
    logic [1:0]          idx;
    logic [3:0]          retry;
    logic [15:0]         gap_cnt;
    logic                nack;
    logic [NUM_REQ-1:0]  gnt_onehot;

    function automatic logic [7:0] byte_at(input logic [1:0] i,
                                           input logic [15:0] a,
                                           input logic [7:0] d);
        case (i)
            2'd0:    byte_at = {DEV_ADDR, 1'b0};
            2'd1:    byte_at = a[15:8];
            2'd2:    byte_at = a[7:0];
            default: byte_at = d;
        endcase
    endfunction

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ)) cand = cand - (GW+1)'(NUM_REQ);
            if (!pick_found && req_valid[cand[GW-1:0]]) begin
                pick_found = 1'b1;
                pick       = cand[GW-1:0];
            end
        end
    end

    assign gnt_onehot = NUM_REQ'(1) << gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt           <= '0;
            lat_addr      <= '0;
            lat_data      <= '0;
            idx           <= '0;
            retry         <= '0;
            gap_cnt       <= '0;
            nack          <= 1'b0;
            req_ready     <= '0;
            req_done      <= '0;
            req_err       <= '0;
            busy          <= 1'b0;
            eng_cmd_valid <= 1'b0;
            eng_cmd_start <= 1'b0;
            eng_cmd_stop  <= 1'b0;
            eng_cmd_byte  <= '0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt      <= pick;
                        lat_addr <= req_addr[{pick, 4'b0000} +: 16];
                        lat_data <= req_data[{pick, 3'b000} +: 8];
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    req_ready     <= gnt_onehot;
                    idx           <= 2'd0;
                    retry         <= '0;
                    nack          <= 1'b0;
                    eng_cmd_valid <= 1'b1;
                    eng_cmd_start <= 1'b1;
                    eng_cmd_stop  <= 1'b0;
                    eng_cmd_byte  <= byte_at(2'd0, lat_addr, lat_data);
                    state         <= SEND;
                end
                SEND: begin
                    if (eng_cmd_ready) begin
                        eng_cmd_valid <= 1'b0;
                        eng_cmd_start <= 1'b0;
                        state         <= WAIT_BYTE;
                    end
                end
                WAIT_BYTE: begin
                    if (eng_done) begin
                        eng_cmd_valid <= 1'b1;
                        if (eng_ack && idx != 2'd3) begin
                            idx          <= idx + 2'd1;
                            eng_cmd_byte <= byte_at(idx + 2'd1, lat_addr, lat_data);
                            state        <= SEND;
                        end else begin
                            // A NACK abandons the remaining bytes and closes the bus.
                            nack         <= ~eng_ack;
                            eng_cmd_stop <= 1'b1;
                            state        <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (eng_cmd_ready) begin
                        eng_cmd_valid <= 1'b0;
                        eng_cmd_stop  <= 1'b0;
                        state         <= WAIT_STOP;
                    end
                end
                WAIT_STOP: begin
                    if (eng_done) begin
                        if (nack && int'(retry) < MAX_RETRY) begin
                            retry   <= retry + 4'd1;
                            gap_cnt <= 16'(RETRY_GAP);
                            state   <= GAP;
                        end else begin
                            req_done <= gnt_onehot;
                            req_err  <= nack ? gnt_onehot : '0;
                            state    <= RESP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt == 16'd1) begin
                        idx           <= 2'd0;
                        eng_cmd_valid <= 1'b1;
                        eng_cmd_start <= 1'b1;
                        eng_cmd_byte  <= byte_at(2'd0, lat_addr, lat_data);
                        state         <= SEND;
                    end
                end
                RESP: begin
                    rr_ptr <= (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// Testbench for codec_cfg_arbiter: an I2C engine model plus a transaction-level
// reference model that predicts grants, command streams, retry gaps and errors.
module tb_codec_cfg_arbiter;

    localparam int         NR   = 3;
    localparam int         MR   = 3;
    localparam int         GAPN = 20;
    localparam logic [6:0] DEV  = 7'h3B;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [16*NR-1:0]  req_addr;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic              busy;
    logic              eng_cmd_valid;
    logic              eng_cmd_ready;
    logic              eng_cmd_start;
    logic              eng_cmd_stop;
    logic [7:0]        eng_cmd_byte;
    logic              eng_done;
    logic              eng_ack;

    codec_cfg_arbiter #(
        .NUM_REQ(NR), .DEV_ADDR(DEV), .MAX_RETRY(MR), .RETRY_GAP(GAPN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .busy(busy),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
        .eng_cmd_start(eng_cmd_start), .eng_cmd_stop(eng_cmd_stop),
        .eng_cmd_byte(eng_cmd_byte), .eng_done(eng_done), .eng_ack(eng_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [9:0]  obs_q[$];
    logic [9:0]  exp_q[$];
    int          gap_q[$];
    bit          nack_tab[16][4];
    int          eng_attempt = -1;
    int          eng_pos     = 0;
    int          dly_min     = 0;
    int          dly_max     = 0;
    bit          rdy_random  = 1'b0;
    int          stall_pos   = -1;
    int          stall_len   = 20;
    bit          stall_armed = 1'b0;
    logic [7:0]  stall_exp   = '0;
    logic [15:0] ra[NR];
    logic [7:0]  rd[NR];
    int          m_rr        = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after the one following the last served.
    function automatic int model_pick(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++)
            if (mask[(m_rr + k) % NR]) return (m_rr + k) % NR;
        return -1;
    endfunction

    // Expected command stream {start,stop,byte} for one request under nack_tab.
    function automatic void model_txn(input logic [15:0] a, input logic [7:0] d,
                                      output bit err, output int attempts);
        logic [7:0] b[4];
        bit nacked;
        b[0] = {DEV, 1'b0};
        b[1] = a[15:8];
        b[2] = a[7:0];
        b[3] = d;
        exp_q.delete();
        err = 1'b1;
        attempts = 0;
        for (int t = 0; t <= MR; t++) begin
            nacked = 1'b0;
            attempts++;
            for (int p = 0; p < 4 && !nacked; p++) begin
                exp_q.push_back({p == 0, 1'b0, b[p]});
                nacked = nack_tab[t][p];
            end
            exp_q.push_back({2'b01, 8'h00});
            if (!nacked) begin
                err = 1'b0;
                break;
            end
        end
    endfunction

    // Engine model: accepts commands, answers with a done pulse after a delay.
    initial begin : engine
        bit         hs, pend, pend_ack, pend_stop, gap_armed;
        logic [9:0] hs_cmd;
        int         pend_dly, cyc, stop_cyc, stall_left;
        hs = 0; pend = 0; pend_ack = 0; pend_stop = 0; gap_armed = 0;
        hs_cmd = '0; pend_dly = 0; cyc = 0; stop_cyc = 0; stall_left = 0;
        eng_cmd_ready = 1'b0;
        eng_done      = 1'b0;
        eng_ack       = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            eng_done = 1'b0;
            eng_ack  = 1'b0;
            if (!rst_n) begin
                hs = 0; pend = 0; gap_armed = 0; stall_left = 0;
                eng_cmd_ready = 1'b0;
            end else begin
                if (hs) begin
                    hs = 0;
                    obs_q.push_back(hs_cmd);
                    if (hs_cmd[9]) begin
                        eng_attempt++;
                        eng_pos = 0;
                    end
                    pend_stop = hs_cmd[8];
                    if (pend_stop) pend_ack = 1'($urandom_range(1, 0));
                    else if (eng_attempt >= 0 && eng_attempt < 16 && eng_pos < 4)
                        pend_ack = !nack_tab[eng_attempt][eng_pos];
                    else pend_ack = 1'b1;
                    if (!pend_stop) eng_pos++;
                    pend_dly = $urandom_range(dly_max, dly_min);
                    pend = 1;
                end
                if (pend) begin
                    if (pend_dly == 0) begin
                        eng_done = 1'b1;
                        eng_ack  = pend_ack;
                        pend     = 0;
                        if (pend_stop) begin
                            gap_armed = 1;
                            stop_cyc  = cyc;
                        end
                    end else pend_dly--;
                end
                if (req_done != '0) gap_armed = 0;
                if (gap_armed && eng_cmd_valid) begin
                    gap_q.push_back(cyc - stop_cyc - 1);
                    gap_armed = 0;
                end
                eng_cmd_ready = 1'b0;
                if (stall_left > 0) begin
                    stall_left--;
                    check_output("stall_valid", 32'(eng_cmd_valid), 32'd1);
                    check_output("stall_byte", 32'(eng_cmd_byte), 32'(stall_exp));
                end else if (eng_cmd_valid && !pend) begin
                    if (stall_armed && !eng_cmd_start && !eng_cmd_stop && eng_pos == stall_pos) begin
                        stall_armed = 1'b0;
                        stall_left  = stall_len;
                    end else begin
                        eng_cmd_ready = rdy_random ? 1'($urandom_range(1, 0)) : 1'b1;
                        hs     = eng_cmd_ready;
                        hs_cmd = {eng_cmd_start, eng_cmd_stop, eng_cmd_byte};
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input int r, input logic [15:0] a, input logic [7:0] d);
        ra[r] = a;
        rd[r] = d;
        req_addr[16*r +: 16] = a;
        req_data[8*r +: 8]   = d;
        req_valid[r]         = 1'b1;
    endtask

    task automatic wait_grant(output int g, output int lat);
        int exp_g;
        exp_g = model_pick(req_valid);
        g = -1;
        lat = 0;
        while (g < 0 && lat < 200) begin
            @(negedge clk);
            lat++;
            for (int k = 0; k < NR; k++)
                if (req_ready[k]) g = k;
        end
        check_output("grant", 32'(g), 32'(exp_g));
        eng_attempt = -1;
    endtask

    task automatic wait_done(input int g);
        bit   exp_err, obs_err;
        int   attempts, seen, n;
        logic [9:0] msk;
        model_txn(ra[g], rd[g], exp_err, attempts);
        seen = -1;
        obs_err = 1'b0;
        for (int c = 0; c < 5000 && seen < 0; c++) begin
            @(negedge clk);
            if (req_done != '0) begin
                check_output("done_onehot", 32'($countones(req_done)), 32'd1);
                for (int k = 0; k < NR; k++)
                    if (req_done[k]) begin
                        seen = k;
                        obs_err = req_err[k];
                    end
            end
        end
        check_output("done_idx", 32'(seen), 32'(g));
        check_output("done_err", 32'(obs_err), 32'(exp_err));
        check_output("cmd_count", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            msk = exp_q[i][8] ? 10'h300 : 10'h3FF;
            check_output("cmd", 32'(obs_q[i] & msk), 32'(exp_q[i]));
        end
        check_output("gap_count", 32'(gap_q.size()), 32'(attempts - 1));
        foreach (gap_q[i]) check_output("gap_len", 32'(gap_q[i]), 32'(GAPN));
        m_rr = (g + 1) % NR;
        obs_q.delete();
        gap_q.delete();
    endtask

    task automatic clear_nacks();
        for (int t = 0; t < 16; t++)
            for (int p = 0; p < 4; p++) nack_tab[t][p] = 1'b0;
    endtask

    initial begin : main
        int g, lat, r;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        clear_nacks();
        #3;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(eng_cmd_valid), 32'd0);
        check_output("rst_ready", 32'(req_ready), 32'd0);
        check_output("rst_done", 32'(req_done), 32'd0);
        check_output("rst_byte", 32'(eng_cmd_byte), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round robin with two requesters held valid throughout.
        apply_stimulus(0, 16'h1234, 8'hA5);
        apply_stimulus(1, 16'hBEEF, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, lat);
            check_output("rr_order", 32'(g), 32'(i % 2));
            wait_done(g);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Single write with an ideal engine; checks grant latency and busy release.
        apply_stimulus(0, 16'h4015, 8'h01);
        wait_grant(g, lat);
        check_output("grant_latency", 32'(lat), 32'd2);
        req_valid[0] = 1'b0;
        wait_done(g);
        @(negedge clk);
        check_output("busy_idle", 32'(busy), 32'd0);

        // NACK on the register high byte during the first attempt only.
        nack_tab[0][1] = 1'b1;
        apply_stimulus(1, 16'h4015, 8'h01);
        wait_grant(g, lat);
        req_valid[1] = 1'b0;
        wait_done(g);
        clear_nacks();

        // Device address NACKed on every attempt.
        for (int t = 0; t < 16; t++) nack_tab[t][0] = 1'b1;
        apply_stimulus(2, 16'h4015, 8'h01);
        wait_grant(g, lat);
        req_valid[2] = 1'b0;
        wait_done(g);
        clear_nacks();

        // Engine backpressure while the register low byte is offered.
        stall_pos   = 2;
        stall_exp   = 8'h15;
        stall_armed = 1'b1;
        apply_stimulus(0, 16'h4015, 8'h01);
        wait_grant(g, lat);
        req_valid[0] = 1'b0;
        wait_done(g);
        stall_armed = 1'b0;

        // Randomized requests, NACK patterns, ready and completion timing.
        rdy_random = 1'b1;
        dly_max    = 3;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(NR - 1, 0);
            for (int t = 0; t < 16; t++)
                for (int p = 0; p < 4; p++) nack_tab[t][p] = ($urandom_range(3, 0) == 0);
            apply_stimulus(r, 16'($urandom), 8'($urandom));
            wait_grant(g, lat);
            req_valid[r] = 1'b0;
            wait_done(g);
        end
        clear_nacks();
        rdy_random = 1'b0;
        dly_max    = 0;

        // Leave rr_ptr at 2, then reset in the middle of a transaction.
        apply_stimulus(1, 16'h2233, 8'h44);
        wait_grant(g, lat);
        req_valid[1] = 1'b0;
        wait_done(g);
        dly_min = 10;
        dly_max = 10;
        apply_stimulus(1, 16'hA0B1, 8'h77);
        wait_grant(g, lat);
        req_valid[1] = 1'b0;
        for (int c = 0; c < 100 && obs_q.size() < 3; c++) @(negedge clk);
        check_output("reach_idx2", 32'(obs_q.size() >= 3), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_rst_valid", 32'(eng_cmd_valid), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_start", 32'(eng_cmd_start), 32'd0);
        check_output("mid_rst_stop", 32'(eng_cmd_stop), 32'd0);
        check_output("mid_rst_byte", 32'(eng_cmd_byte), 32'd0);
        check_output("mid_rst_done", 32'({req_done, req_err, req_ready}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        dly_min = 0;
        dly_max = 0;
        m_rr    = 0;
        obs_q.delete();
        gap_q.delete();

        apply_stimulus(1, 16'h0102, 8'h03);
        apply_stimulus(2, 16'h0405, 8'h06);
        wait_grant(g, lat);
        check_output("post_rst_first", 32'(g), 32'd1);
        req_valid[1] = 1'b0;
        wait_done(g);
        wait_grant(g, lat);
        req_valid[2] = 1'b0;
        wait_done(g);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
